// File: rtl/io_spi_master.sv
// rtl/io_spi_master.sv - Byte-wide mode-0 SPI master on the dma_io bus with read-chain stage
module io_spi_master #(
    parameter logic [15:0] ADR_BASE = 16'hC200,
    parameter logic [7:0]  DIV_RST  = 8'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_io_we,
    input  logic [15:2] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [15:2] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        spi_interrupt_1shot
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    logic [7:0]  ctrl_div;
    logic        ctrl_cs;
    logic        ctrl_ie;
    logic        busy;
    logic        done;
    logic        coll;
    logic [7:0]  tx_shift;
    logic [7:0]  rx_shift;
    logic [7:0]  rxdata;
    logic [7:0]  div_act;
    logic [7:0]  cnt;
    logic [2:0]  bit_cnt;
    logic [1:0]  state;
    logic        rd_hit;
    logic [31:0] rd_data;
    logic [31:0] rd_sel;

    logic w_hit;
    logic wr_ctrl;
    logic wr_stat;
    logic wr_tx;
    logic r_hit;
    logic unused_wdata;

    assign w_hit   = dma_io_we && (dma_io_wadr[15:4] == ADR_BASE[15:4]);
    assign wr_ctrl = w_hit && (dma_io_wadr[3:2] == 2'd0);
    assign wr_stat = w_hit && (dma_io_wadr[3:2] == 2'd1);
    assign wr_tx   = w_hit && (dma_io_wadr[3:2] == 2'd2);
    assign r_hit   = dma_io_radr_en && (dma_io_radr[15:4] == ADR_BASE[15:4]);

    assign unused_wdata = ^dma_io_wdata[31:10];

    assign spi_cs_n     = ~ctrl_cs;
    assign dma_io_rdata = rd_hit ? rd_data : dma_io_rdata_in;

    always_comb begin
        rd_sel = 32'd0;
        case (dma_io_radr[3:2])
            2'd0:    rd_sel = {22'd0, ctrl_ie, ctrl_cs, ctrl_div};
            2'd1:    rd_sel = {29'd0, coll, done, busy};
            2'd3:    rd_sel = {24'd0, rxdata};
            default: rd_sel = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_div <= DIV_RST;
            ctrl_cs  <= 1'b0;
            ctrl_ie  <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_div <= dma_io_wdata[7:0];
            ctrl_cs  <= dma_io_wdata[8];
            ctrl_ie  <= dma_io_wdata[9];
        end
    end

    // Capturing before this edge's writes makes a same-cycle STATUS read see the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_hit  <= 1'b0;
            rd_data <= 32'd0;
        end else begin
            rd_hit <= r_hit;
            if (r_hit) begin
                rd_data <= rd_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            busy                <= 1'b0;
            done                <= 1'b0;
            coll                <= 1'b0;
            tx_shift            <= 8'd0;
            rx_shift            <= 8'd0;
            rxdata              <= 8'd0;
            div_act             <= 8'd0;
            cnt                 <= 8'd0;
            bit_cnt             <= 3'd0;
            spi_sck             <= 1'b0;
            spi_mosi            <= 1'b0;
            spi_interrupt_1shot <= 1'b0;
        end else begin
            spi_interrupt_1shot <= 1'b0;

            if (wr_stat) begin
                if (dma_io_wdata[1]) done <= 1'b0;
                if (dma_io_wdata[2]) coll <= 1'b0;
            end

            // BUSY is still high on the edge that finishes a byte, so a write there collides.
            if (wr_tx) begin
                if (busy) begin
                    coll <= 1'b1;
                end else begin
                    tx_shift <= dma_io_wdata[7:0];
                    div_act  <= ctrl_div;
                    state    <= ST_LOW;
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    spi_mosi <= dma_io_wdata[7];
                    cnt      <= 8'd0;
                    bit_cnt  <= 3'd0;
                end
            end

            case (state)
                ST_LOW: begin
                    if (cnt == div_act) begin
                        cnt      <= 8'd0;
                        spi_sck  <= 1'b1;
                        rx_shift <= {rx_shift[6:0], spi_miso};
                        state    <= ST_HIGH;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (cnt == div_act) begin
                        cnt     <= 8'd0;
                        spi_sck <= 1'b0;
                        if (bit_cnt != 3'd7) begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            spi_mosi <= tx_shift[6];
                            bit_cnt  <= bit_cnt + 3'd1;
                            state    <= ST_LOW;
                        end else begin
                            rxdata              <= rx_shift;
                            busy                <= 1'b0;
                            done                <= 1'b1;
                            spi_mosi            <= 1'b0;
                            state               <= ST_IDLE;
                            spi_interrupt_1shot <= ctrl_ie;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
